// File: rtl/memc_pkg.sv
// Shared constants and types for the systolic-array output deskew buffer.
// Optional sticky overrun flag is enabled by defining MEMC_OVERRUN_EN.
package memc_pkg;

    localparam int MEMC_DIM    = 8;
    localparam int MEMC_BITS_C = 24;

    localparam int MEMC_STEP_W = $clog2(2 * MEMC_DIM - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } memc_state_t;

    typedef logic [MEMC_STEP_W-1:0] memc_step_t;

    // Step at which the bottom-right element C[DIM-1][DIM-1] leaves the array.
    localparam memc_step_t LAST_STEP = memc_step_t'(2 * MEMC_DIM - 2);

endpackage

// File: rtl/memc_deskew_col_capture.sv
// One column of result storage: writes C[t-COL][COL] while the skew window
// covers this column, and offers an asynchronous read of any stored row.
module col_capture
    import memc_pkg::*;
#(
    parameter int DIM    = MEMC_DIM,
    parameter int BITS_C = MEMC_BITS_C,
    parameter int COL    = 0,
    parameter int STEP_W = $clog2(2 * DIM - 1),
    parameter int ROW_W  = $clog2(DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [STEP_W-1:0] t,
    input  logic [BITS_C-1:0] din,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [BITS_C-1:0] rd_data
);

    logic [BITS_C-1:0] mem_q [DIM];
    logic [BITS_C-1:0] mem_d [DIM];
    int                row_i;

    // Row index is t-COL; signed int keeps the lower window bound meaningful.
    always_comb begin
        mem_d = mem_q;
        row_i = int'(t) - COL;
        if (cap_en && (row_i >= 0) && (row_i < DIM)) begin
            mem_d[ROW_W'(row_i)] = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see mem_q, so a same-cycle write to the addressed row is not visible.
    assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/memc_deskew.sv
// Re-aligns the diagonally skewed C stream from a DIM x DIM systolic array into
// row storage and serves whole rows via a registered read port. Optional
// sticky overrun flag (start during capture) under MEMC_OVERRUN_EN.
module memc_deskew
    import memc_pkg::*;
#(
    parameter int BITS_C = MEMC_BITS_C,
    parameter int DIM    = MEMC_DIM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic [DIM*BITS_C-1:0]   Cin,
    input  logic [$clog2(DIM)-1:0]  Crow,
    input  logic                    RdEn,
    output logic [DIM*BITS_C-1:0]   Cout,
`ifdef MEMC_OVERRUN_EN
    output logic                    ovr,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int STEP_W = $clog2(2 * DIM - 1);
    localparam int ROW_W  = $clog2(DIM);
    localparam logic [STEP_W-1:0] T_LAST = STEP_W'(2 * DIM - 2);

    memc_state_t             state_q, state_d;
    logic [STEP_W-1:0]       t_q, t_d;
    logic [DIM*BITS_C-1:0]   cout_q, cout_d;
    logic [DIM*BITS_C-1:0]   rd_bus;
    logic                    cap_en;

    assign cap_en = (state_q == CAPTURE) && en;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    t_d     = '0;
                end
            end
            CAPTURE: begin
                // start is deliberately ignored here; the matrix in flight finishes.
                if (en) begin
                    if (t_q == T_LAST) begin
                        state_d = FULL;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    state_d = CAPTURE;
                    t_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    always_comb begin
        cout_d = cout_q;
        if (RdEn) begin
            cout_d = rd_bus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cout_q  <= cout_d;
        end
    end

    for (genvar j = 0; j < DIM; j++) begin : g_col
        col_capture #(
            .DIM    (DIM),
            .BITS_C (BITS_C),
            .COL    (j),
            .STEP_W (STEP_W),
            .ROW_W  (ROW_W)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .cap_en  (cap_en),
            .t       (t_q),
            .din     (Cin[j*BITS_C +: BITS_C]),
            .rd_row  (Crow),
            .rd_data (rd_bus[j*BITS_C +: BITS_C])
        );
    end

`ifdef MEMC_OVERRUN_EN
    logic ovr_q, ovr_d;

    // An accepted start clears the flag; set only on a start seen mid-capture.
    always_comb begin
        ovr_d = ovr_q;
        if (start && (state_q == CAPTURE)) begin
            ovr_d = 1'b1;
        end
        if (start && (state_q != CAPTURE)) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr = ovr_q;
`endif

    assign Cout = cout_q;
    assign busy = (state_q == CAPTURE);
    assign done = (state_q == FULL);

endmodule

// File: tb/tb_memc_deskew.sv
// Directed bench for memc_deskew with a matrix-level reference model checked
// every cycle, plus literal expectations on key values and timings.
module tb_memc_deskew;

    localparam int DIM = 8;
    localparam int BW  = 24;
    localparam int VW  = DIM * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start;
    logic [VW-1:0] cin;
    logic [2:0]    crow;
    logic          rd_en;
    logic [VW-1:0] cout;
    logic          busy;
    logic          done;
`ifdef MEMC_OVERRUN_EN
    logic          ovr;
`endif

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memc_deskew #(.BITS_C(BW), .DIM(DIM)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .Cin   (cin),
        .Crow  (crow),
        .RdEn  (rd_en),
        .Cout  (cout),
`ifdef MEMC_OVERRUN_EN
        .ovr   (ovr),
`endif
        .busy  (busy),
        .done  (done)
    );

    // Reference model: the result matrix, capture progress and the read register.
    logic [BW-1:0] m_buf [DIM][DIM];
    logic [VW-1:0] m_cout;
    bit            m_cap;
    bit            m_full;
    int            m_steps;
`ifdef MEMC_OVERRUN_EN
    bit            m_ovr;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++)
                for (int j = 0; j < DIM; j++)
                    m_buf[r][j] <= '0;
            m_cout  <= '0;
            m_cap   <= 1'b0;
            m_full  <= 1'b0;
            m_steps <= 0;
`ifdef MEMC_OVERRUN_EN
            m_ovr   <= 1'b0;
`endif
        end else begin
            if (m_cap && en) begin
                for (int j = 0; j < DIM; j++)
                    if (m_steps - j >= 0 && m_steps - j < DIM)
                        m_buf[m_steps - j][j] <= cin[j*BW +: BW];
                if (m_steps == 2 * DIM - 2) begin
                    m_cap   <= 1'b0;
                    m_full  <= 1'b1;
                    m_steps <= 0;
                end else begin
                    m_steps <= m_steps + 1;
                end
            end
            if (start) begin
                if (m_cap) begin
`ifdef MEMC_OVERRUN_EN
                    m_ovr <= 1'b1;
`endif
                end else begin
                    m_cap   <= 1'b1;
                    m_full  <= 1'b0;
                    m_steps <= 0;
`ifdef MEMC_OVERRUN_EN
                    m_ovr   <= 1'b0;
`endif
                end
            end
            if (rd_en)
                for (int j = 0; j < DIM; j++)
                    m_cout[j*BW +: BW] <= m_buf[crow][j];
        end
    end

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cycle_cout", cout, m_cout);
        check("cycle_busy", VW'(busy), VW'(m_cap));
        check("cycle_done", VW'(done), VW'(m_full));
`ifdef MEMC_OVERRUN_EN
        check("cycle_ovr", VW'(ovr), VW'(m_ovr));
`endif
    end

    function automatic logic [BW-1:0] pat(input int mode, input int r, input int j);
        case (mode)
            0:       return BW'(100 * r + j);
            1:       return BW'(7);
            2:       return BW'(9);
            default: return '0;
        endcase
    endfunction

    function automatic logic [VW-1:0] row_vec(input int mode, input int r);
        logic [VW-1:0] v;
        for (int j = 0; j < DIM; j++) v[j*BW +: BW] = pat(mode, r, j);
        return v;
    endfunction

    task automatic drive_step(input int mode, input int s);
        cin = '0;
        for (int j = 0; j < DIM; j++)
            if (s - j >= 0 && s - j < DIM) cin[j*BW +: BW] = pat(mode, s - j, j);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        en    = 1'b0;
        rd_en = 1'b0;
        cin   = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives capture steps s_from..s_to-1; optional gaps, start pulse and read at a step.
    task automatic run_steps(input int mode, input int s_from, input int s_to, input bit gap3,
                             input int start_at, input int rd_at, output int ncyc);
        int s = s_from;
        int c = 0;
        while (s < s_to) begin
            en    = !(gap3 && (c % 3 == 2));
            start = en && (s == start_at);
            rd_en = en && (s == rd_at);
            crow  = 3'd3;
            if (en) drive_step(mode, s);
            else cin = '0;
            @(negedge clk);
            if (en) s++;
            c++;
        end
        en    = 1'b0;
        start = 1'b0;
        rd_en = 1'b0;
        cin   = '0;
        ncyc  = c;
    endtask

    task automatic read_row(input int r, output logic [VW-1:0] v);
        crow  = 3'(r);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        v     = cout;
    endtask

    task automatic check_all_rows(input string name, input int mode);
        logic [VW-1:0] v;
        for (int r = 0; r < DIM; r++) begin
            read_row(r, v);
            check(name, v, row_vec(mode, r));
        end
    endtask

    initial begin
        int            n;
        logic [VW-1:0] v;
        logic [VW-1:0] mix;

        rst = 1'b1; en = 1'b0; start = 1'b0; rd_en = 1'b0; crow = '0; cin = '0;
        repeat (2) @(negedge clk);
        check("rst_cout", cout, '0);
        check("rst_busy", VW'(busy), '0);
        check("rst_done", VW'(done), '0);
        rst = 1'b0;

        // Basic capture
        do_start();
        check("start_busy", VW'(busy), VW'(1));
        run_steps(0, 0, 15, 1'b0, -1, -1, n);
        check("basic_cycles", VW'(n), VW'(15));
        check("basic_done", VW'(done), VW'(1));
        check_all_rows("basic_row", 0);
        read_row(2, v);
        check("lit_r2c5", VW'(v[5*BW +: BW]), VW'(205));
        read_row(7, v);
        check("lit_r7c7", VW'(v[7*BW +: BW]), VW'(707));

        // en gaps every third cycle
        do_start();
        run_steps(0, 0, 15, 1'b1, -1, -1, n);
        check("gap_cycles", VW'(n), VW'(22));
        check("gap_done", VW'(done), VW'(1));
        check_all_rows("gap_row", 0);

        // Restart from FULL
        do_start();
        run_steps(1, 0, 15, 1'b0, -1, -1, n);
        check("fill7_done", VW'(done), VW'(1));
        do_start();
        check("restart_done_low", VW'(done), '0);
        run_steps(2, 0, 4, 1'b0, -1, -1, n);
        read_row(0, v);
        for (int j = 0; j < DIM; j++) mix[j*BW +: BW] = (j < 4) ? BW'(9) : BW'(7);
        check("mid_row0", v, mix);
        run_steps(2, 4, 15, 1'b0, -1, -1, n);
        check("fill9_done", VW'(done), VW'(1));
        check_all_rows("fill9_row", 2);

        // Start pulse during capture
        do_start();
        run_steps(0, 0, 15, 1'b0, 5, -1, n);
        check("ovr_cycles", VW'(n), VW'(15));
        check("ovr_done", VW'(done), VW'(1));
`ifdef MEMC_OVERRUN_EN
        check("ovr_set", VW'(ovr), VW'(1));
`endif
        do_start();
`ifdef MEMC_OVERRUN_EN
        check("ovr_clr", VW'(ovr), '0);
`endif

        // Reset mid-capture
        run_steps(0, 0, 6, 1'b0, -1, -1, n);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", VW'(busy), '0);
        check("midrst_done", VW'(done), '0);
        check("midrst_cout", cout, '0);
        check_all_rows("midrst_row", 3);
        do_start();
        run_steps(0, 0, 15, 1'b0, -1, -1, n);
        read_row(5, v);
        check("after_rst_row5", v, row_vec(0, 5));

        // Read/write collision on row 3 at step 3
        do_start();
        run_steps(2, 0, 4, 1'b0, -1, 3, n);
        check("coll_old", VW'(cout[0 +: BW]), VW'(300));
        read_row(3, v);
        check("coll_new_c0", VW'(v[0 +: BW]), VW'(9));
        check("coll_new_c1", VW'(v[BW +: BW]), VW'(301));
        run_steps(2, 4, 15, 1'b0, -1, -1, n);
        read_row(3, v);
        check("coll_final", v, row_vec(2, 3));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/memc_deskew.md
Name: memc_deskew

Overview:
- Output-side counterpart of the A/B operand skew path.
- Captures the diagonally skewed result stream leaving the bottom of the DIM x DIM systolic array, one element per column per enabled cycle.
- Re-aligns the stream into row-addressable storage and serves whole C rows over a registered read port.
- Sits between the systolic array outputs and the result read-back logic.

Parameters:
- BITS_C, 24, signed width of one C element (accumulator width).
- DIM, 8, array dimension: number of columns, rows and storage rows.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  array advance strobe; capture progresses only on cycles with en=1.
- start  input  1  one-cycle pulse; begins a new capture sequence.
- Cin  input  DIM x BITS_C signed  column outputs of the array; Cin[j] is column j.
- Crow  input  $clog2(DIM)  read row address.
- RdEn  input  1  read request.
- Cout  output  DIM x BITS_C signed  registered row data; Cout[j] = C[Crow][j].
- busy  output  1  high while in CAPTURE.
- done  output  1  high while in FULL, meaning all DIM*DIM elements are stored.

Behaviour:
- Reset, asynchronous: state=IDLE, step counter t=0, all storage cleared to 0, Cout=0, busy=0, done=0.
- Skew convention: element C[r][j] is presented on Cin[j] at capture step t = r + j. Steps 0..2*DIM-2 form one result matrix.
- FSM states are IDLE, CAPTURE and FULL.
- IDLE:
  - start=1 -> CAPTURE, t=0.
  - The start cycle itself captures nothing; step 0 is the first en=1 cycle after start.
- CAPTURE:
  - On each en=1 cycle, for every column j with 0 <= t-j <= DIM-1, store Cin[j] into buf[t-j][j].
  - Columns outside that window ignore Cin. Then t=t+1.
  - en=0 cycles: no store; t holds.
  - When the store at t = 2*DIM-2 occurs: go to FULL and reset t to 0. done rises the cycle after that last store.
  - start asserted during CAPTURE is ignored; capture is not restarted.
- FULL:
  - Storage is frozen.
  - start=1 -> CAPTURE, t=0, done falls the next cycle. Old contents stay readable until overwritten element by element.
- Read port:
  - Legal in any state.
  - RdEn=1 at edge k -> Cout = buf[Crow] after edge k, i.e. 1-cycle latency.
  - RdEn=0 -> Cout holds its previous value.
  - Reading a row that is being written in the same cycle returns the pre-write value (read-before-write).
  - Reads in IDLE or CAPTURE are not blocked; the reader qualifies data with done.
- No arithmetic: Cin is stored bit-exact, with no truncation or extension.
- Reset mid-capture: immediate IDLE, storage cleared, done=0. A partially captured matrix is discarded.

Optional Feature:
- Macro: MEMC_OVERRUN_EN.
- With the macro defined:
  - Extra output port ovr (1 bit, reset 0), sticky.
  - ovr is set on any cycle where start=1 while in CAPTURE.
  - ovr is cleared only by rst or by a start accepted from IDLE/FULL. If that start collides with a set condition, clear wins.
- Without the macro: no ovr port; start during CAPTURE is silently ignored as above.

Decomposition:
- Package memc_pkg holds:
  - default DIM and BITS_C localparams;
  - typedef enum logic [1:0] {IDLE, CAPTURE, FULL} memc_state_t;
  - typedef for the step counter, width $clog2(2*DIM-1);
  - the helper constant LAST_STEP = 2*DIM-2.
- Sub-module col_capture, one instance per column j via generate:
  - holds the DIM-deep column storage;
  - computes its write enable from t, j and en;
  - exposes an asynchronous read of the addressed row.
- The top owns the FSM, the step counter and the Cout register.

Test Plan:
- Basic: rst; start; drive Cin[j] = 100*(t-j)+j inside the window, 0 outside, en=1 for 15 cycles (DIM=8). Required: done=1 on the cycle after the 15th store; reading each Crow=r returns Cout[j] = 100*r+j one cycle after RdEn.
- en gaps: same data with en=0 inserted on every third cycle. Required: identical stored matrix; done delayed by exactly the number of inserted gap cycles.
- Restart from FULL: fill with value 7 everywhere, then start and capture value 9. Required: done falls after start; mid-capture, row 0 reads 9 in completed columns and 7 in the rest; final matrix is all 9.
- Start during CAPTURE: pulse start at step 5. Required: capture continues and done arrives at the same cycle as with no pulse; with MEMC_OVERRUN_EN, ovr=1 from the cycle after the pulse until the next accepted start.
- Reset mid-capture: assert rst at step 6. Required: busy=0, done=0, Cout=0 and all rows read 0 after release; a new start then captures correctly.
- Read/write collision: RdEn on Crow=3 in the same cycle step t=3 writes buf[3][0]. Required: Cout[0] shows the old value; the next read shows the new value.
